alu_decode_stage: RTL



---
 rtl/alu_decode_stage_pkg.sv | 93 +++++++++
 rtl/alu_decode_stage_imm_gen.sv | 25 ++
 rtl/alu_decode_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_pkg.sv
// Shared decode/ALU definitions: RV32I opcodes, 6-bit ALU operation codes and
// the helpers that map funct3 onto them. Used by the decode stage and the ALU.
// No ports; purely declarations and combinational helper functions.
package alu_decode_stage_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Modifier bit positions inside the 6-bit aluop
    localparam int ALUOP_NZ  = 5;   // invert the zero flag
    localparam int ALUOP_U   = 4;   // unsigned compare
    localparam int ALUOP_NEG = 3;   // subtract

    localparam logic [5:0] ALUOP_ADD  = 6'h00;
    localparam logic [5:0] ALUOP_SLT  = 6'h01 | (6'd1 << ALUOP_NEG);
    localparam logic [5:0] ALUOP_AND  = 6'h02;
    localparam logic [5:0] ALUOP_OR   = 6'h03;
    localparam logic [5:0] ALUOP_XOR  = 6'h04;
    localparam logic [5:0] ALUOP_SLL  = 6'h05;
    localparam logic [5:0] ALUOP_SRL  = 6'h06;
    localparam logic [5:0] ALUOP_SRA  = 6'h07;
    localparam logic [5:0] ALUOP_SUB  = ALUOP_ADD | (6'd1 << ALUOP_NEG);
    localparam logic [5:0] ALUOP_SLTU = ALUOP_SLT | (6'd1 << ALUOP_U);

    // Branches reuse sub/slt; "taken" is always zero-flag == 1 after optional inversion
    localparam logic [5:0] ALUOP_BEQ  = ALUOP_SUB;
    localparam logic [5:0] ALUOP_BNE  = ALUOP_SUB  | (6'd1 << ALUOP_NZ);
    localparam logic [5:0] ALUOP_BLT  = ALUOP_SLT  | (6'd1 << ALUOP_NZ);
    localparam logic [5:0] ALUOP_BGE  = ALUOP_SLT;
    localparam logic [5:0] ALUOP_BLTU = ALUOP_SLTU | (6'd1 << ALUOP_NZ);
    localparam logic [5:0] ALUOP_BGEU = ALUOP_SLTU;

    // Registered ID/EX bundle (valid is kept separately)
    typedef struct packed {
        logic [5:0]  aluop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] storedata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        isbranch;
        logic        isjump;
        logic        illegal;
    } id_ex_t;

    // Register-register and register-immediate arithmetic share one table;
    // funct7[5] only selects sub for the register form, but selects sra for both.
    function automatic logic [5:0] arith_aluop(input logic [2:0] funct3,
                                               input logic       alt,
                                               input logic       is_imm);
        logic [5:0] code;
        case (funct3)
            3'b000:  code = (alt && !is_imm) ? ALUOP_SUB : ALUOP_ADD;
            3'b001:  code = ALUOP_SLL;
            3'b010:  code = ALUOP_SLT;
            3'b011:  code = ALUOP_SLTU;
            3'b100:  code = ALUOP_XOR;
            3'b101:  code = alt ? ALUOP_SRA : ALUOP_SRL;
            3'b110:  code = ALUOP_OR;
            default: code = ALUOP_AND;
        endcase
        return code;
    endfunction

    // Returns ALUOP_ADD for the two undefined branch funct3 values;
    // the caller flags those as illegal.
    function automatic logic [5:0] branch_aluop(input logic [2:0] funct3);
        logic [5:0] code;
        case (funct3)
            3'b000:  code = ALUOP_BEQ;
            3'b001:  code = ALUOP_BNE;
            3'b100:  code = ALUOP_BLT;
            3'b101:  code = ALUOP_BGE;
            3'b110:  code = ALUOP_BLTU;
            3'b111:  code = ALUOP_BGEU;
            default: code = ALUOP_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J immediate format from the opcode.
// Purely combinational, zero latency, no flow control.
// Ports: instr (32-bit instruction) in, imm (sign-extended immediate) out; 0 for formats without one.
module alu_decode_stage_imm_gen
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: imm = {{20{instr[31]}}, instr[31:20]};
            STORE:              imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         imm = {instr[31:12], 12'b0};
            JAL:                imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                       instr[20], instr[30:21], 1'b0};
            default:            imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX decode stage: turns an RV32I instruction plus rs1/rs2 reads into the ALU control/operand bundle.
// Latency: one cycle from accepted ID input to ex_* outputs; no combinational id_* -> ex_* path.
// Backpressure: ex_stall_i holds the register (id_ready_o = ~ex_stall_i); ex_flush_i kills it and wins over stall.
// Ports: id_* instruction side (valid/ready handshake), ex_* registered bundle, illegal_cnt_o saturating debug count.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [31:0]      id_instr_i,
    input  logic [31:0]      id_pc_i,
    input  logic [31:0]      id_datars1_i,
    input  logic [31:0]      id_datars2_i,
    input  logic             ex_stall_i,
    input  logic             ex_flush_i,
    output logic             ex_valid_o,
    output logic [5:0]       ex_aluop_o,
    output logic [31:0]      ex_operand1_o,
    output logic [31:0]      ex_operand2_o,
    output logic [31:0]      ex_imm_o,
    output logic [31:0]      ex_storedata_o,
    output logic [31:0]      ex_pc_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_regwrite_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             ex_isbranch_o,
    output logic             ex_isjump_o,
    output logic             ex_illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    logic [31:0]      imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alt;
    logic             load;
    id_ex_t           dec;
    id_ex_t           bundle;
    logic             valid;
    logic [CNT_W-1:0] count;

    alu_decode_stage_imm_gen u_imm_gen (
        .instr (id_instr_i),
        .imm   (imm)
    );

    assign opcode = id_instr_i[6:0];
    assign funct3 = id_instr_i[14:12];
    assign alt    = id_instr_i[30];

    assign load       = id_valid_i & ~ex_stall_i & ~ex_flush_i;
    assign id_ready_o = ~ex_stall_i;

    // Combinational decode. Illegal encodings fall through with aluop=ADD and
    // every write/mem flag low, so a stray illegal bundle has no side effects.
    always_comb begin
        dec           = '0;
        dec.op1       = id_datars1_i;
        dec.op2       = id_datars2_i;
        dec.imm       = imm;
        dec.storedata = id_datars2_i;
        dec.pc        = id_pc_i;
        dec.rd        = id_instr_i[11:7];
        case (opcode)
            OP: begin
                dec.aluop    = arith_aluop(funct3, alt, 1'b0);
                dec.regwrite = 1'b1;
            end
            OP_IMM: begin
                dec.aluop    = arith_aluop(funct3, alt, 1'b1);
                // Shifts take the raw 5-bit shamt; funct7 bits must not leak into op2
                dec.op2      = (funct3 == 3'b001 || funct3 == 3'b101)
                               ? {27'b0, id_instr_i[24:20]} : imm;
                dec.regwrite = 1'b1;
            end
            LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    dec.op2      = imm;
                    dec.memread  = 1'b1;
                    dec.regwrite = 1'b1;
                end else begin
                    dec.illegal  = 1'b1;
                end
            end
            STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    dec.op2      = imm;
                    dec.memwrite = 1'b1;
                end else begin
                    dec.illegal  = 1'b1;
                end
            end
            BRANCH: begin
                if (funct3 inside {3'b010, 3'b011}) begin
                    dec.illegal  = 1'b1;
                end else begin
                    dec.aluop    = branch_aluop(funct3);
                    dec.isbranch = 1'b1;
                end
            end
            LUI: begin
                dec.op1      = '0;
                dec.op2      = imm;
                dec.regwrite = 1'b1;
            end
            AUIPC: begin
                dec.op1      = id_pc_i;
                dec.op2      = imm;
                dec.regwrite = 1'b1;
            end
            JAL: begin
                // ALU computes the link address pc+4; the target uses imm
                dec.op1      = id_pc_i;
                dec.op2      = 32'd4;
                dec.isjump   = 1'b1;
                dec.regwrite = 1'b1;
            end
            JALR: begin
                if (funct3 == 3'b000) begin
                    dec.op1      = id_pc_i;
                    dec.op2      = 32'd4;
                    dec.isjump   = 1'b1;
                    dec.regwrite = 1'b1;
                end else begin
                    dec.illegal  = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // x0 is hard-wired; never request a write to it
        if (dec.rd == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    // ID/EX register. Flush beats stall; on flush or bubble only valid and the
    // control flags are cleared, data fields keep whatever they held.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid  <= 1'b0;
            bundle <= '0;
            count  <= '0;
        end else begin
            if (ex_flush_i || (!ex_stall_i && !id_valid_i)) begin
                valid           <= 1'b0;
                bundle.regwrite <= 1'b0;
                bundle.memread  <= 1'b0;
                bundle.memwrite <= 1'b0;
                bundle.isbranch <= 1'b0;
                bundle.isjump   <= 1'b0;
                bundle.illegal  <= 1'b0;
            end else if (!ex_stall_i) begin
                valid  <= 1'b1;
                bundle <= dec;
            end
            if (load && dec.illegal && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end
        end
    end

    assign ex_valid_o     = valid;
    assign ex_aluop_o     = bundle.aluop;
    assign ex_operand1_o  = bundle.op1;
    assign ex_operand2_o  = bundle.op2;
    assign ex_imm_o       = bundle.imm;
    assign ex_storedata_o = bundle.storedata;
    assign ex_pc_o        = bundle.pc;
    assign ex_rd_o        = bundle.rd;
    assign ex_regwrite_o  = bundle.regwrite;
    assign ex_memread_o   = bundle.memread;
    assign ex_memwrite_o  = bundle.memwrite;
    assign ex_isbranch_o  = bundle.isbranch;
    assign ex_isjump_o    = bundle.isjump;
    assign ex_illegal_o   = bundle.illegal;
    assign illegal_cnt_o  = count;

endmodule
